// File: rtl/serial_msg_engine.sv
// serial_msg_engine
//   Host link protocol engine. Parses framed host messages (type, length,
//   payload[, checksum]), delivers work to the work manager, queues nonce
//   results in a FIFO and serialises responses/results back over the UART.
//
//   Optional feature macro: SERIAL_CHECKSUM_EN
//     defined   -> every rx frame carries a trailing XOR byte (checked, NACK on
//                  mismatch) and every tx frame appends the same XOR byte.
//     undefined -> no checksum byte in either direction.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   rx_data      received byte, valid when new_rx_data pulses
//   new_rx_data  one-cycle rx strobe
//   tx_data      byte to transmit, valid when new_tx_data pulses
//   new_tx_data  one-cycle transmit strobe
//   tx_busy      UART transmitter busy
//   new_work     one-cycle pulse when work_data is (re)issued
//   work_data    work payload, byte i at bits [8i+7:8i]
//   new_result   one-cycle strobe for result_data
//   result_data  nonce result to report to the host
//   result_drops saturating count of results lost to a full FIFO
module serial_msg_engine #(
  parameter int          WORK_BYTES     = 80,
  parameter int          RESULT_BYTES   = 4,
  parameter int          RESULT_DEPTH   = 4,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] DEVICE_ID      = "MoV4"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      new_rx_data,
  output logic [7:0]                tx_data,
  output logic                      new_tx_data,
  input  logic                      tx_busy,
  output logic                      new_work,
  output logic [8*WORK_BYTES-1:0]   work_data,
  input  logic                      new_result,
  input  logic [8*RESULT_BYTES-1:0] result_data,
  output logic [7:0]                result_drops
);

  localparam logic [7:0] T_ACK       = 8'd2;
  localparam logic [7:0] T_NACK      = 8'd4;
  localparam logic [7:0] T_PING      = 8'd8;
  localparam logic [7:0] T_INFO      = 8'd18;
  localparam logic [7:0] T_NEW_WORK  = 8'd19;
  localparam logic [7:0] T_RESTART   = 8'd20;
  localparam logic [7:0] T_TEST_WORK = 8'd21;
  localparam logic [7:0] T_RESULT    = 8'd32;
  localparam logic [7:0] T_ERROR     = 8'd254;

  localparam logic [7:0] WB_LEN  = 8'(WORK_BYTES);
  localparam logic [7:0] RB_LEN  = 8'(RESULT_BYTES);
  localparam int         PAY_MAX = 16;
  localparam int         AW      = $clog2(RESULT_DEPTH);
  localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_TYPE, RX_LEN, RX_PAYLOAD, RX_CSUM, DISPATCH, TX_BYTE, TX_GAP
  } state_t;

`ifdef SERIAL_CHECKSUM_EN
  localparam state_t     AFTER_PAY = RX_CSUM;
  localparam logic [7:0] TX_TRAIL  = 8'd2;  // index of last tx byte = len + 2
`else
  localparam state_t     AFTER_PAY = DISPATCH;
  localparam logic [7:0] TX_TRAIL  = 8'd1;
`endif

  // Bit n set when n is prime; TEST_WORK requires payload byte n == n there.
  function automatic logic [255:0] prime_mask();
    logic [255:0] m;
    m = '0;
    for (int n = 2; n < 256; n++) begin
      logic p;
      p = 1'b1;
      for (int d = 2; d * d <= n; d++)
        if (n % d == 0) p = 1'b0;
      m[n] = p;
    end
    return m;
  endfunction

  localparam logic [255:0] PRIME_MASK = prime_mask();

  state_t                   state;
  logic [7:0]               msg_type, msg_len, byte_cnt, rx_csum;
  logic                     test_ok, frame_err, csum_bad;
  logic [TW-1:0]            to_cnt;
  logic [8*WORK_BYTES-1:0]  work_buf;
  logic [7:0]               tx_type, tx_len, tx_idx, tx_byte;
  logic [8*PAY_MAX-1:0]     tx_pay;
`ifdef SERIAL_CHECKSUM_EN
  logic [7:0]               tx_csum;
`endif

  logic [8*RESULT_BYTES-1:0] fifo_mem [RESULT_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [AW:0]               fifo_cnt;
  logic                      fifo_empty, fifo_full, pop_en, push_en, drop_en;
  logic                      rx_active, to_fire;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(RESULT_DEPTH));
  // Results only go out from an idle receiver, so a response always wins.
  assign pop_en     = (state == RX_TYPE) && !new_rx_data && !fifo_empty;
  assign push_en    = new_result && (!fifo_full || pop_en);
  assign drop_en    = new_result && fifo_full && !pop_en;

  assign rx_active  = (state == RX_LEN) || (state == RX_PAYLOAD) || (state == RX_CSUM);
  assign to_fire    = rx_active && !new_rx_data && (to_cnt == TO_LAST);

  // Current outgoing byte: type, length, payload, then optional checksum.
  always_comb begin
    tx_byte = 8'h00;
    for (int i = 0; i < PAY_MAX; i++)
      if (tx_idx == 8'(i + 2)) tx_byte = tx_pay[8*i +: 8];
`ifdef SERIAL_CHECKSUM_EN
    if (tx_idx == tx_len + 8'd2) tx_byte = tx_csum;
`endif
    if (tx_idx == 8'd0) tx_byte = tx_type;
    if (tx_idx == 8'd1) tx_byte = tx_len;
  end

  // Result FIFO
  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_ptr] <= result_data;
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      result_drops <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop_en && result_drops != 8'hFF) result_drops <= result_drops + 8'd1;
    end
  end

  // Payload capture: bytes beyond WORK_BYTES never reach the buffer.
  always_ff @(posedge clk) begin
    if (state == RX_PAYLOAD && new_rx_data)
      for (int i = 0; i < WORK_BYTES; i++)
        if (byte_cnt == 8'(i)) work_buf[8*i +: 8] <= rx_data;
  end

  // Protocol FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RX_TYPE;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      new_work    <= 1'b0;
      work_data   <= '0;
      to_cnt      <= '0;
      msg_type    <= '0;
      msg_len     <= '0;
      byte_cnt    <= '0;
      rx_csum     <= '0;
      test_ok     <= 1'b1;
      frame_err   <= 1'b0;
      csum_bad    <= 1'b0;
      tx_type     <= '0;
      tx_len      <= '0;
      tx_idx      <= '0;
      tx_pay      <= '0;
`ifdef SERIAL_CHECKSUM_EN
      tx_csum     <= '0;
`endif
    end else begin
      new_work    <= 1'b0;
      new_tx_data <= 1'b0;
      if (rx_active && !new_rx_data) to_cnt <= to_cnt + TW'(1);
      else                           to_cnt <= '0;

      case (state)
        RX_TYPE: begin
          if (new_rx_data) begin
            msg_type  <= rx_data;
            rx_csum   <= rx_data;
            test_ok   <= 1'b1;
            frame_err <= 1'b0;
            csum_bad  <= 1'b0;
            state     <= RX_LEN;
          end else if (pop_en) begin
            tx_type <= T_RESULT;
            tx_len  <= RB_LEN;
            tx_pay  <= (8*PAY_MAX)'(fifo_mem[rd_ptr]);
            tx_idx  <= '0;
`ifdef SERIAL_CHECKSUM_EN
            tx_csum <= '0;
`endif
            state   <= TX_BYTE;
          end
        end

        RX_LEN: begin
          if (new_rx_data) begin
            msg_len  <= rx_data;
            rx_csum  <= rx_csum ^ rx_data;
            byte_cnt <= '0;
            state    <= (rx_data == 8'd0) ? AFTER_PAY : RX_PAYLOAD;
          end else if (to_fire) begin
            frame_err <= 1'b1;
            state     <= DISPATCH;
          end
        end

        RX_PAYLOAD: begin
          if (new_rx_data) begin
            rx_csum  <= rx_csum ^ rx_data;
            byte_cnt <= byte_cnt + 8'd1;
            if (PRIME_MASK[byte_cnt] && rx_data != byte_cnt) test_ok <= 1'b0;
            if (byte_cnt == msg_len - 8'd1) state <= AFTER_PAY;
          end else if (to_fire) begin
            frame_err <= 1'b1;
            state     <= DISPATCH;
          end
        end

        RX_CSUM: begin
          if (new_rx_data) begin
            csum_bad <= (rx_data != rx_csum);
            state    <= DISPATCH;
          end else if (to_fire) begin
            frame_err <= 1'b1;
            state     <= DISPATCH;
          end
        end

        DISPATCH: begin
          tx_idx  <= '0;
          tx_len  <= '0;
          tx_pay  <= '0;
          tx_type <= T_ERROR;
`ifdef SERIAL_CHECKSUM_EN
          tx_csum <= '0;
`endif
          state   <= TX_BYTE;
          // A timed-out frame has no trailing byte, so frame_err is checked first.
          if (frame_err) begin
            tx_type <= T_ERROR;
          end else if (csum_bad) begin
            tx_type <= T_NACK;
          end else begin
            case (msg_type)
              T_PING: tx_type <= T_ACK;
              T_INFO: begin
                tx_type     <= T_INFO;
                tx_len      <= 8'd4;
                tx_pay[31:0] <= {DEVICE_ID[7:0], DEVICE_ID[15:8],
                                 DEVICE_ID[23:16], DEVICE_ID[31:24]};
              end
              T_NEW_WORK: begin
                if (msg_len == WB_LEN) begin
                  work_data <= work_buf;
                  new_work  <= 1'b1;
                  tx_type   <= T_ACK;
                end
              end
              T_TEST_WORK: begin
                if (msg_len == WB_LEN) begin
                  if (test_ok) begin
                    work_data <= work_buf;
                    new_work  <= 1'b1;
                    tx_type   <= T_ACK;
                  end else begin
                    tx_type   <= T_NACK;
                  end
                end
              end
              T_RESTART: begin
                new_work <= 1'b1;
                tx_type  <= T_ACK;
              end
              default: tx_type <= T_ERROR;
            endcase
          end
        end

        TX_BYTE: begin
          if (!tx_busy) begin
            tx_data     <= tx_byte;
            new_tx_data <= 1'b1;
`ifdef SERIAL_CHECKSUM_EN
            tx_csum     <= tx_csum ^ tx_byte;
`endif
            state       <= TX_GAP;
          end
        end

        TX_GAP: begin
          if (tx_idx == tx_len + TX_TRAIL) begin
            state <= RX_TYPE;
          end else begin
            tx_idx <= tx_idx + 8'd1;
            state  <= TX_BYTE;
          end
        end

        default: state <= RX_TYPE;
      endcase
    end
  end

endmodule
